// File: rtl/spi_master_ctrl.sv
// SPI-style sequencer for a LOAD/SCLK shift-register slave: pre-LOAD, WIDTH
// MSB-first bits, post-LOAD, then a one-cycle DONE carrying the received word.
module spi_master_ctrl #(
  parameter int WIDTH    = 9,
  parameter int HALF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             load,
  output logic             mosi,
  input  logic             miso
);

  localparam int PW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(HALF_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOW,
    S_HIGH,
    S_TAIL,
    S_LOAD_B,
    S_DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    phase;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             phase_end;

  assign phase_end = (phase == PH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      sclk    <= 1'b0;
      load    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // The cycle after DONE still has busy set, so a held START waits one cycle.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            tx_sr   <= tx_data;
            bit_cnt <= '0;
            phase   <= '0;
            busy    <= 1'b1;
            load    <= 1'b1;
            state   <= S_LOAD_A;
          end
        end

        S_DONE: begin
          done    <= 1'b1;
          rx_data <= rx_sr;
          mosi    <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          phase <= phase_end ? '0 : phase + 1'b1;
          if (phase_end) begin
            case (state)
              S_LOAD_A: begin
                load  <= 1'b0;
                mosi  <= tx_sr[WIDTH-1];
                state <= S_LOW;
              end
              S_LOW: begin
                sclk  <= 1'b1;
                state <= S_HIGH;
              end
              S_HIGH: begin
                // MISO is still stable here: the slave only shifts after SCLK falls.
                rx_sr   <= {rx_sr[WIDTH-2:0], miso};
                bit_cnt <= bit_cnt + 1'b1;
                sclk    <= 1'b0;
                if (bit_cnt == BIT_LAST) begin
                  state <= S_TAIL;
                end else begin
                  tx_sr <= tx_sr << 1;
                  mosi  <= tx_sr[WIDTH-2];
                  state <= S_LOW;
                end
              end
              S_TAIL: begin
                load  <= 1'b1;
                state <= S_LOAD_B;
              end
              S_LOAD_B: begin
                load  <= 1'b0;
                state <= S_DONE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (HALF_DIV=2 and HALF_DIV=1), each
// talking to a behavioural LOAD/SCLK shift-register slave.
module tb_spi_master_ctrl;

  logic clk;
  logic rst_n;

  logic       start_a, busy_a, done_a, sclk_a, load_a, mosi_a, miso_a;
  logic [8:0] tx_a, rx_a;
  logic       start_b, busy_b, done_b, sclk_b, load_b, mosi_b, miso_b;
  logic [8:0] tx_b, rx_b;

  logic [8:0] di_a, sr_a, do_a;
  logic [8:0] di_b, sr_b, do_b;
  logic       in_a, in_b;
  bit         dirty_a, dirty_b;
  int         nsclk_a = 0, nload_a = 0, nsclk_b = 0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [8:0] tx;
    logic [8:0] di;
    bit         inject;
    logic [8:0] exp_rx;
    logic [8:0] exp_do;
  } vec_t;

  vec_t vecs[4];

  spi_master_ctrl #(.WIDTH(9), .HALF_DIV(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a),
    .busy(busy_a), .done(done_a), .rx_data(rx_a),
    .sclk(sclk_a), .load(load_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_master_ctrl #(.WIDTH(9), .HALF_DIV(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b),
    .sclk(sclk_b), .load(load_b), .mosi(mosi_b), .miso(miso_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: LOAD rise commits a shifted word to DO and reloads from DI;
  // samples MOSI on SCLK rise, shifts on SCLK fall, MISO = shift-register MSB.
  always @(posedge load_a or negedge sclk_a) begin
    if (load_a) begin
      if (dirty_a) do_a <= sr_a;
      sr_a    <= di_a;
      dirty_a <= 1'b0;
    end else begin
      sr_a    <= {sr_a[7:0], in_a};
      dirty_a <= 1'b1;
    end
  end
  always @(posedge sclk_a) in_a <= mosi_a;
  assign miso_a = sr_a[8];

  always @(posedge load_b or negedge sclk_b) begin
    if (load_b) begin
      if (dirty_b) do_b <= sr_b;
      sr_b    <= di_b;
      dirty_b <= 1'b0;
    end else begin
      sr_b    <= {sr_b[7:0], in_b};
      dirty_b <= 1'b1;
    end
  end
  always @(posedge sclk_b) in_b <= mosi_b;
  assign miso_b = sr_b[8];

  always @(posedge sclk_a) nsclk_a++;
  always @(posedge load_a) nload_a++;
  always @(posedge sclk_b) nsclk_b++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int done_cyc;
    int ndone;
    int s0;
    int l0;
    done_cyc = -1;
    ndone    = 0;
    s0       = nsclk_a;
    l0       = nload_a;
    di_a     = v.di;
    tx_a     = v.tx;
    start_a  = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    tx_a    = ~v.tx;
    for (int c = 1; c <= 47; c++) begin
      @(posedge clk); #1;
      if (done_a) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 43) chk($sformatf("v%0d_busy_c43", idx), busy_a, 1);
      if (c == 44) chk($sformatf("v%0d_busy_c44", idx), busy_a, 0);
      if (c == 47) chk($sformatf("v%0d_busy_c47", idx), busy_a, 0);
      start_a = v.inject && (c == 5 || c == 43);
    end
    start_a = 1'b0;
    chk($sformatf("v%0d_done_cycle", idx), done_cyc, 43);
    chk($sformatf("v%0d_done_count", idx), ndone, 1);
    chk($sformatf("v%0d_rx_data", idx), rx_a, v.exp_rx);
    chk($sformatf("v%0d_slave_do", idx), do_a, v.exp_do);
    chk($sformatf("v%0d_sclk_rises", idx), nsclk_a - s0, 9);
    chk($sformatf("v%0d_load_pulses", idx), nload_a - l0, 2);
  endtask

  initial begin
    int ndone;
    int done_cyc;
    int s0;

    vecs[0] = '{9'h1A5, 9'h0F3, 1'b0, 9'h0F3, 9'h1A5};
    vecs[1] = '{9'h0F3, 9'h1A5, 1'b1, 9'h1A5, 9'h0F3};
    vecs[2] = '{9'h100, 9'h001, 1'b0, 9'h001, 9'h100};
    vecs[3] = '{9'h0AA, 9'h155, 1'b1, 9'h155, 9'h0AA};

    rst_n   = 1'b0;
    start_a = 1'b0; tx_a = '0; di_a = '0;
    start_b = 1'b0; tx_b = '0; di_b = '0;
    #3;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sclk", sclk_a, 0);
    chk("rst_load", load_a, 0);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_rx", rx_a, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) run_frame(vecs[i], i);

    // Back-to-back with START held high.
    di_a = 9'h0AA; tx_a = 9'h000; start_a = 1'b1;
    @(posedge clk); #1;
    tx_a = 9'h1FF;
    for (int c = 1; c <= 90; c++) begin
      @(posedge clk); #1;
      if (c == 43) begin
        chk("b2b_done1", done_a, 1);
        chk("b2b_rx1", rx_a, 9'h0AA);
        chk("b2b_do1", do_a, 9'h000);
        di_a = 9'h155;
      end
      if (c == 44) chk("b2b_busy_c44", busy_a, 0);
      if (c == 45) chk("b2b_busy_c45", busy_a, 1);
      if (c == 87) chk("b2b_no_early_done2", done_a, 0);
      if (c == 88) begin
        chk("b2b_done2", done_a, 1);
        chk("b2b_rx2", rx_a, 9'h155);
        chk("b2b_do2", do_a, 9'h1FF);
        start_a = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the HIGH phase of bit 4.
    di_a = 9'h0F3; tx_a = 9'h1A5; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_sclk_high", sclk_a, 1);
    chk("mid_busy", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_sclk", sclk_a, 0);
    chk("arst_load", load_a, 0);
    chk("arst_mosi", mosi_a, 0);
    chk("arst_rx", rx_a, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    chk("arst_rx_hold", rx_a, 0);
    chk("arst_idle_busy", busy_a, 0);
    run_frame(vecs[0], 9);

    // HALF_DIV = 1 instance.
    di_b = 9'h14D; tx_b = 9'h0B6; start_b = 1'b1;
    s0 = nsclk_b;
    done_cyc = -1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 2) chk("hd1_sclk_c2", sclk_b, 1);
      if (c == 3) chk("hd1_sclk_c3", sclk_b, 0);
      if (done_b && done_cyc < 0) done_cyc = c;
    end
    chk("hd1_done_cycle", done_cyc, 22);
    chk("hd1_rx", rx_b, 9'h14D);
    chk("hd1_do", do_b, 9'h0B6);
    chk("hd1_sclk_rises", nsclk_b - s0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
